// File: rtl/bp_be_fe_queue_adapter.sv
// FE->BE instruction queue with PC-redirect command generation.
// Define BP_FE_QUEUE_ROLLBACK_EN to keep issued entries until commit and allow rollback.
package bp_be_fe_queue_adapter_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg = 2'd0,
    e_bp_small_cfg   = 2'd1
  } bp_params_e;

  typedef enum logic [3:0] {
    e_op_state_reset          = 4'd0,
    e_op_pc_redirection       = 4'd1,
    e_op_icache_fill_response = 4'd2,
    e_op_icache_fence         = 4'd3
  } bp_fe_command_queue_opcodes_e;

  localparam int fe_instr_width_gp    = 32;
  localparam int fe_queue_meta_width_gp = 8;
  localparam int fe_cmd_misc_width_gp = 8;

  function automatic int vaddr_width_f(bp_params_e cfg);
    return (cfg == e_bp_small_cfg) ? 32 : 39;
  endfunction

  // fe_queue packet: {pc, instr, meta}
  function automatic int fe_queue_width_f(bp_params_e cfg);
    return vaddr_width_f(cfg) + fe_instr_width_gp + fe_queue_meta_width_gp;
  endfunction

  // fe_cmd: {opcode, pc_redirect_operands{pc, misc}}
  function automatic int fe_cmd_width_f(bp_params_e cfg);
    return 4 + vaddr_width_f(cfg) + fe_cmd_misc_width_gp;
  endfunction

endpackage

module bp_be_fe_queue_adapter
  import bp_be_fe_queue_adapter_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_default_cfg,
  parameter int fifo_els_p = 8,
  localparam int vaddr_width_p     = vaddr_width_f(bp_params_p),
  localparam int fe_queue_width_lp = fe_queue_width_f(bp_params_p),
  localparam int fe_cmd_width_lp   = fe_cmd_width_f(bp_params_p),
  localparam int ptr_width_lp      = $clog2(fifo_els_p) + 1
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [fe_queue_width_lp-1:0] fe_queue_i,
  input  logic                         fe_queue_v_i,
  output logic                         fe_queue_ready_o,
  output logic [fe_cmd_width_lp-1:0]   fe_cmd_o,
  output logic                         fe_cmd_v_o,
  input  logic                         fe_cmd_yumi_i,
  output logic [fe_queue_width_lp-1:0] issue_pkt_o,
  output logic                         issue_v_o,
  input  logic                         issue_yumi_i,
  input  logic                         redirect_v_i,
  input  logic [vaddr_width_p-1:0]     redirect_pc_i,
  input  logic                         commit_v_i,
  input  logic                         rollback_v_i,
  output logic [ptr_width_lp-1:0]      count_o
);

  localparam int AW = ptr_width_lp - 1;

  typedef logic [ptr_width_lp-1:0] ptr_t;
  typedef enum logic {e_run = 1'b0, e_cmd = 1'b1} state_e;

  typedef struct packed {
    logic [vaddr_width_p-1:0]        pc;
    logic [fe_cmd_misc_width_gp-1:0] misc;
  } bp_fe_cmd_pc_redirect_operands_s;

  typedef struct packed {
    bp_fe_cmd_pc_redirect_operands_s pc_redirect_operands;
  } bp_fe_cmd_operands_s;

  typedef struct packed {
    bp_fe_command_queue_opcodes_e opcode;
    bp_fe_cmd_operands_s          operands;
  } bp_fe_cmd_s;

  state_e                     r_state;
  ptr_t                       r_wptr;
  ptr_t                       r_rptr;
  ptr_t                       w_cptr;
  logic [vaddr_width_p-1:0]   r_pc;
  logic [fe_queue_width_lp-1:0] r_mem [fifo_els_p];

  logic       w_run;
  logic       w_full;
  logic       w_empty;
  logic       w_enq;
  logic       w_deq;
  bp_fe_cmd_s w_fe_cmd;

`ifdef BP_FE_QUEUE_ROLLBACK_EN
  ptr_t r_cptr;
  logic w_commit;
  assign w_cptr   = r_cptr;
  assign w_commit = commit_v_i & (r_cptr != r_rptr);
`else
  logic w_unused;
  assign w_cptr   = r_rptr;
  assign w_unused = commit_v_i ^ rollback_v_i;
`endif

  assign w_run   = (r_state == e_run);
  // Full is measured against the oldest uncommitted entry, empty against the read pointer.
  assign w_full  = (r_wptr[AW] != w_cptr[AW]) && (r_wptr[AW-1:0] == w_cptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);

  assign fe_queue_ready_o = w_run & ~w_full & ~reset_i;
  assign issue_v_o        = w_run & ~w_empty & ~reset_i;
  assign issue_pkt_o      = r_mem[r_rptr[AW-1:0]];
  assign w_enq            = fe_queue_v_i & fe_queue_ready_o;
  assign w_deq            = issue_yumi_i & issue_v_o;
  assign count_o          = r_wptr - w_cptr;
  assign fe_cmd_v_o       = (r_state == e_cmd);

  always_comb begin
    w_fe_cmd = '0;
    w_fe_cmd.opcode = e_op_pc_redirection;
    w_fe_cmd.operands.pc_redirect_operands.pc = r_pc;
  end
  assign fe_cmd_o = w_fe_cmd;

  always_ff @(posedge clk_i) begin
    if (w_enq) r_mem[r_wptr[AW-1:0]] <= fe_queue_i;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state <= e_run;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_pc    <= '0;
`ifdef BP_FE_QUEUE_ROLLBACK_EN
      r_cptr  <= '0;
`endif
    end else begin
      case (r_state)
        e_run: begin
          if (redirect_v_i) begin
            r_pc    <= redirect_pc_i;
            r_wptr  <= '0;
            r_rptr  <= '0;
`ifdef BP_FE_QUEUE_ROLLBACK_EN
            r_cptr  <= '0;
`endif
            r_state <= e_cmd;
          end else begin
            if (w_enq) r_wptr <= r_wptr + ptr_t'(1);
`ifdef BP_FE_QUEUE_ROLLBACK_EN
            if (w_commit) r_cptr <= r_cptr + ptr_t'(1);
            // Rollback lands on the commit pointer as it will be after this edge.
            if (rollback_v_i) r_rptr <= w_commit ? (r_cptr + ptr_t'(1)) : r_cptr;
            else if (w_deq)   r_rptr <= r_rptr + ptr_t'(1);
`else
            if (w_deq) r_rptr <= r_rptr + ptr_t'(1);
`endif
          end
        end
        e_cmd: begin
          if (redirect_v_i)       r_pc    <= redirect_pc_i;
          else if (fe_cmd_yumi_i) r_state <= e_run;
        end
        default: r_state <= e_run;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_be_fe_queue_adapter.sv
// Directed plus random bench for bp_be_fe_queue_adapter against a queue-based reference model.
// Honours BP_FE_QUEUE_ROLLBACK_EN the same way as the design.
module tb_bp_be_fe_queue_adapter;
  import bp_be_fe_queue_adapter_pkg::*;

  localparam int VA = vaddr_width_f(e_bp_default_cfg);
  localparam int QW = fe_queue_width_f(e_bp_default_cfg);
  localparam int CW = fe_cmd_width_f(e_bp_default_cfg);
  localparam int EL = 8;
  localparam int NW = $clog2(EL) + 1;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [QW-1:0] fe_queue_i = '0;
  logic          fe_queue_v_i = 1'b0;
  logic          fe_queue_ready_o;
  logic [CW-1:0] fe_cmd_o;
  logic          fe_cmd_v_o;
  logic          fe_cmd_yumi_i = 1'b0;
  logic [QW-1:0] issue_pkt_o;
  logic          issue_v_o;
  logic          issue_yumi_i = 1'b0;
  logic          redirect_v_i = 1'b0;
  logic [VA-1:0] redirect_pc_i = '0;
  logic          commit_v_i = 1'b0;
  logic          rollback_v_i = 1'b0;
  logic [NW-1:0] count_o;

  bp_be_fe_queue_adapter #(.bp_params_p(e_bp_default_cfg), .fifo_els_p(EL)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .fe_queue_i(fe_queue_i), .fe_queue_v_i(fe_queue_v_i), .fe_queue_ready_o(fe_queue_ready_o),
    .fe_cmd_o(fe_cmd_o), .fe_cmd_v_o(fe_cmd_v_o), .fe_cmd_yumi_i(fe_cmd_yumi_i),
    .issue_pkt_o(issue_pkt_o), .issue_v_o(issue_v_o), .issue_yumi_i(issue_yumi_i),
    .redirect_v_i(redirect_v_i), .redirect_pc_i(redirect_pc_i),
    .commit_v_i(commit_v_i), .rollback_v_i(rollback_v_i), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Model: mq holds every entry not yet freed, oldest first; nis = issued-but-uncommitted count.
  logic [QW-1:0] mq[$];
  int            nis = 0;
  bit            m_cmd = 1'b0;
  bit            m_rst = 1'b1;
  logic [VA-1:0] m_pc = '0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] cmd_of(input logic [VA-1:0] pc);
    logic [3:0] op;
    op = e_op_pc_redirection;
    return {op, pc, 8'h00};
  endfunction

  function automatic bit m_ready();
    return !m_rst && !m_cmd && (mq.size() < EL);
  endfunction

  function automatic bit m_issue_v();
    return !m_rst && !m_cmd && (nis < mq.size());
  endfunction

  task automatic check_model();
    chk("ready", fe_queue_ready_o, m_ready());
    chk("issue_v", issue_v_o, m_issue_v());
    chk("count", count_o, mq.size());
    chk("fe_cmd_v", fe_cmd_v_o, m_cmd);
    if (m_cmd) chk("fe_cmd", fe_cmd_o, cmd_of(m_pc));
    if (m_issue_v()) chk("issue_pkt", issue_pkt_o, mq[nis]);
  endtask

  task automatic model_edge();
    bit enq, yumi_ok, commit_ok;
    enq     = fe_queue_v_i && m_ready();
    yumi_ok = issue_yumi_i && m_issue_v();
    if (m_rst) return;
    if (redirect_v_i) begin
      mq.delete();
      nis   = 0;
      m_pc  = redirect_pc_i;
      m_cmd = 1'b1;
    end else if (m_cmd) begin
      if (fe_cmd_yumi_i) m_cmd = 1'b0;
    end else begin
`ifdef BP_FE_QUEUE_ROLLBACK_EN
      commit_ok = commit_v_i && (nis > 0);
      if (commit_ok) void'(mq.pop_front());
      if (rollback_v_i) nis = 0;
      else nis = nis + int'(yumi_ok) - int'(commit_ok);
`else
      commit_ok = 1'b0;
      if (yumi_ok) void'(mq.pop_front());
`endif
      if (enq) mq.push_back(fe_queue_i);
    end
  endtask

  // Inputs are set at the negedge; compare, advance model, cross the posedge, return at next negedge.
  task automatic cyc();
    #1;
    check_model();
    model_edge();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle();
    fe_queue_v_i = 0; issue_yumi_i = 0; redirect_v_i = 0; fe_cmd_yumi_i = 0;
    commit_v_i = 0; rollback_v_i = 0;
  endtask

  function automatic logic [QW-1:0] rnd_pkt();
    logic [95:0] r;
    r = {$urandom, $urandom, $urandom};
    return r[QW-1:0];
  endfunction

  function automatic logic [VA-1:0] rnd_pc();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[VA-1:0];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [QW-1:0] pa, pb, pc;
    // Reset state
    #3;
    chk("rst_ready", fe_queue_ready_o, 1'b0);
    chk("rst_issue_v", issue_v_o, 1'b0);
    chk("rst_cmd_v", fe_cmd_v_o, 1'b0);
    chk("rst_count", count_o, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0; m_rst = 1'b0;
    #1 chk("ready_after_rst", fe_queue_ready_o, 1'b1);

    // Fill to full with no issue
    for (int i = 0; i < EL; i++) begin
      fe_queue_v_i = 1; fe_queue_i = rnd_pkt(); cyc();
    end
    idle();
    #1;
    chk("full_ready", fe_queue_ready_o, 1'b0);
    chk("full_count", count_o, EL);
    // Full: ready stays low even with a pop and offered packet in the same cycle
    fe_queue_v_i = 1; fe_queue_i = rnd_pkt(); issue_yumi_i = 1;
    #1 chk("full_ready_yumi", fe_queue_ready_o, 1'b0);
    cyc();
`ifdef BP_FE_QUEUE_ROLLBACK_EN
    idle(); commit_v_i = 1; cyc();
`endif
    idle();
    #1;
    chk("pop_ready", fe_queue_ready_o, 1'b1);
    chk("pop_count", count_o, EL - 1);

    // Drain down to 5 held entries, then redirect with competing inputs
    for (int i = 0; i < 10 && mq.size() > 5; i++) begin
      issue_yumi_i = 1; commit_v_i = 1; cyc();
    end
    idle();
    chk("held5", count_o, 5);
    redirect_v_i = 1; redirect_pc_i = VA'(64'h8000_0040);
    fe_queue_v_i = 1; fe_queue_i = rnd_pkt(); issue_yumi_i = 1; commit_v_i = 1; rollback_v_i = 1;
    cyc();
    idle();
    #1;
    chk("redir_cmd_v", fe_cmd_v_o, 1'b1);
    chk("redir_cmd", fe_cmd_o, cmd_of(VA'(64'h8000_0040)));
    chk("redir_issue_v", issue_v_o, 1'b0);
    chk("redir_count", count_o, 0);
    chk("redir_ready", fe_queue_ready_o, 1'b0);

    // Back-to-back redirects in e_cmd, held until consumed
    redirect_v_i = 1; redirect_pc_i = VA'(32'h100); cyc();
    redirect_v_i = 1; redirect_pc_i = VA'(32'h200); cyc();
    idle(); cyc(); cyc();
    chk("cmd_pc_200", fe_cmd_o, cmd_of(VA'(32'h200)));
    fe_cmd_yumi_i = 1; cyc();
    idle();
    #1;
    chk("yumi_cmd_v", fe_cmd_v_o, 1'b0);
    chk("yumi_ready", fe_queue_ready_o, 1'b1);

    // Redirect and yumi together in e_cmd
    redirect_v_i = 1; redirect_pc_i = VA'(32'h300); cyc();
    redirect_v_i = 1; redirect_pc_i = VA'(32'h400); fe_cmd_yumi_i = 1; cyc();
    idle();
    #1;
    chk("redir_yumi_cmd_v", fe_cmd_v_o, 1'b1);
    chk("redir_yumi_pc", fe_cmd_o, cmd_of(VA'(32'h400)));
    fe_cmd_yumi_i = 1; cyc();
    idle();

`ifdef BP_FE_QUEUE_ROLLBACK_EN
    pa = rnd_pkt(); pb = rnd_pkt(); pc = rnd_pkt();
    fe_queue_v_i = 1; fe_queue_i = pa; cyc();
    fe_queue_i = pb; cyc();
    fe_queue_i = pc; cyc();
    idle();
    for (int i = 0; i < 3; i++) begin issue_yumi_i = 1; cyc(); end
    idle(); commit_v_i = 1; cyc();
    idle(); rollback_v_i = 1; cyc();
    idle();
    #1;
    chk("rb_pkt_b", issue_pkt_o, pb);
    chk("rb_count", count_o, 2);
    issue_yumi_i = 1; cyc();
    idle();
    #1 chk("rb_pkt_c", issue_pkt_o, pc);
    rollback_v_i = 1; cyc();
    idle();
`else
    pa = '0; pb = '0; pc = '0;
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      fe_queue_v_i  = ($urandom_range(0, 3) != 0);
      fe_queue_i    = rnd_pkt();
      issue_yumi_i  = $urandom_range(0, 1);
      commit_v_i    = $urandom_range(0, 1);
      rollback_v_i  = ($urandom_range(0, 7) == 0);
      redirect_v_i  = ($urandom_range(0, 19) == 0);
      redirect_pc_i = rnd_pc();
      fe_cmd_yumi_i = $urandom_range(0, 1);
      cyc();
    end
    idle();
    for (int i = 0; i < 4; i++) begin fe_cmd_yumi_i = 1; cyc(); end
    idle();

    // Asynchronous reset in the middle of e_cmd
    redirect_v_i = 1; redirect_pc_i = VA'(32'h500); cyc();
    idle();
    #2;
    chk("pre_rst_cmd_v", fe_cmd_v_o, 1'b1);
    reset_i = 1'b1;
    #1;
    chk("async_rst_cmd_v", fe_cmd_v_o, 1'b0);
    chk("async_rst_ready", fe_queue_ready_o, 1'b0);
    chk("async_rst_count", count_o, 0);
    mq.delete(); nis = 0; m_cmd = 1'b0; m_pc = '0; m_rst = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    reset_i = 1'b0; m_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("post_rst_no_cmd", fe_cmd_v_o, 1'b0);
      fe_cmd_yumi_i = 1; cyc();
    end
    idle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bp_be_fe_queue_adapter.md
BP_BE_FE_QUEUE_ADAPTER -- requirements
Module: bp_be_fe_queue_adapter

Interface
REQ-001 SHALL have parameter bp_params_p, default e_bp_default_cfg; selects the processor configuration and the fe_queue/fe_cmd struct widths.
REQ-002 SHALL have parameter fifo_els_p, default 8; gives the fe_queue buffer depth (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port fe_queue_i  input  fe_queue_width_lp  fetched-instruction packet from FE.
REQ-006 SHALL have port fe_queue_v_i  input  1  fe_queue_i valid.
REQ-007 SHALL have port fe_queue_ready_o  output  1  adapter can accept a packet (ready/valid).
REQ-008 SHALL have port fe_cmd_o  output  fe_cmd_width_lp  command to FE (bp_fe_cmd_s).
REQ-009 SHALL have port fe_cmd_v_o  output  1  fe_cmd_o valid.
REQ-010 SHALL have port fe_cmd_yumi_i  input  1  FE consumed fe_cmd_o (valid->yumi).
REQ-011 SHALL have port issue_pkt_o  output  fe_queue_width_lp  head packet to the BE issue stage.
REQ-012 SHALL have port issue_v_o  output  1  issue_pkt_o valid.
REQ-013 SHALL have port issue_yumi_i  input  1  issue stage consumed the head packet.
REQ-014 SHALL have port redirect_v_i  input  1  BE requests a PC redirect.
REQ-015 SHALL have port redirect_pc_i  input  vaddr_width_p  redirect target.
REQ-016 SHALL have port commit_v_i  input  1  oldest issued packet retires.
REQ-017 SHALL have port rollback_v_i  input  1  re-present all issued-but-uncommitted packets.
REQ-018 SHALL have port count_o  output  $clog2(fifo_els_p)+1  valid entries held.

Function
REQ-019 SHALL have a two-state FSM: e_run and e_cmd.
REQ-020 SHALL, in e_run, drive fe_queue_ready_o = ~full; a packet is enqueued on fe_queue_v_i & fe_queue_ready_o.
REQ-021 SHALL, in e_run, drive issue_v_o = ~empty and issue_pkt_o = the entry at the read pointer; issue_yumi_i advances the read pointer by 1.
REQ-022 SHALL provide no bypass: a packet enqueued at edge N is presentable on issue_pkt_o from cycle N+1.
REQ-023 SHALL keep fe_queue_ready_o low when full, even if issue_yumi_i is high the same cycle.
REQ-024 SHALL wrap pointers modulo fifo_els_p and use an extra MSB to distinguish full from empty.
REQ-025 SHALL, on redirect_v_i in e_run, latch redirect_pc_i, discard every entry (all pointers to 0), and enter e_cmd at the same edge.
REQ-026 SHALL give redirect_v_i priority over a simultaneous enqueue, issue_yumi_i, commit_v_i or rollback_v_i (all ignored).
REQ-027 SHALL, in e_cmd, drive fe_cmd_v_o=1 with opcode e_op_pc_redirection, operands.pc_redirect_operands.pc = latched PC, other fields 0; fe_queue_ready_o=0 and issue_v_o=0.
REQ-028 SHALL return to e_run on fe_cmd_yumi_i.
REQ-029 SHALL, if redirect_v_i is high in e_cmd, overwrite the latched PC and remain in e_cmd even if fe_cmd_yumi_i is also high.
REQ-030 SHALL hold fe_cmd_o stable while fe_cmd_v_o is high and not consumed.
REQ-031 SHALL drive count_o = write pointer minus commit pointer.

Reset
REQ-032 SHALL, while reset_i is high, immediately force state e_run, all pointers 0, latched PC 0, fe_cmd_v_o=0, issue_v_o=0, fe_queue_ready_o=0, count_o=0.
REQ-033 SHALL drive fe_queue_ready_o=1 from the first cycle after reset deasserts.
REQ-034 SHALL lose any in-flight redirect when reset asserts mid-e_cmd; no fe_cmd is issued afterwards.

Configuration
REQ-035 SHALL, with BP_FE_QUEUE_ROLLBACK_EN defined, keep a separate commit pointer: commit_v_i advances it by 1 (only when commit < read); full is computed against the commit pointer; rollback_v_i sets read pointer = commit pointer at the edge.
REQ-036 SHALL, with BP_FE_QUEUE_ROLLBACK_EN undefined, keep the commit pointer equal to the read pointer, so issue_yumi_i frees the entry; commit_v_i and rollback_v_i are ignored but the ports remain.

Verification
REQ-037 SHALL cover: fill 8 packets with issue_yumi_i=0 -> fe_queue_ready_o=0, count_o=8; pop one -> ready=1 next cycle.
REQ-038 SHALL cover: redirect_v_i pc=0x8000_0040 with 5 entries held -> next cycle fe_cmd_v_o=1, pc 0x8000_0040, issue_v_o=0, count_o=0.
REQ-039 SHALL cover: in e_cmd redirect 0x100 then 0x200 while fe_cmd_yumi_i=0 -> fe_cmd_o pc=0x200; yumi -> e_run, ready=1.
REQ-040 SHALL cover: redirect_v_i and fe_cmd_yumi_i together in e_cmd -> remains e_cmd with the new PC.
REQ-041 SHALL cover, with rollback enabled: issue A,B,C, commit A, rollback -> issue_pkt_o=B, then C; count_o=2.
REQ-042 SHALL cover: reset_i asserted mid-e_cmd -> fe_cmd_v_o=0 without waiting for a clock edge, no command after deassert.
